// File: rtl/mem_lsu_pkg.sv
// Shared widths, size encodings, FSM states and alignment helpers for the LSU.
package mem_lsu_pkg;

  localparam int XLEN   = 64;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_DBL  = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_WR_REQ  = 3'd2,
    S_WR_WAIT = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  // An access is misaligned when the byte offset is not a multiple of its size.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      SZ_BYTE: lsu_misaligned = 1'b0;
      SZ_HALF: lsu_misaligned = off[0];
      SZ_WORD: lsu_misaligned = |off[1:0];
      default: lsu_misaligned = |off;
    endcase
  endfunction

  // Byte-enable pattern for an access of the given size at offset 0.
  function automatic logic [7:0] size_byte_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_byte_mask = 8'h01;
      SZ_HALF: size_byte_mask = 8'h03;
      SZ_WORD: size_byte_mask = 8'h0F;
      default: size_byte_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Bundle of the EX, arbiter and WB signals seen by the LSU.
interface mem_lsu_if;
  import mem_lsu_pkg::*;

  logic              ex_valid_i;
  logic              ex_ready_o;
  logic              ex_is_store_i;
  logic [1:0]        ex_size_i;
  logic              ex_unsigned_i;
  logic [ADDR_W-1:0] ex_addr_i;
  logic [XLEN-1:0]   ex_wdata_i;
  logic [4:0]        ex_rd_i;

  logic [ADDR_W-1:0] mem_read_addr_o;
  logic              mem_valid_o;
  logic [7:0]        mem_rmask_o;
  logic [XLEN-1:0]   mem_rdata_i;
  logic              mem_rdata_valid_i;

  logic [ADDR_W-1:0] mem_write_addr_o;
  logic              mem_write_valid_o;
  logic [7:0]        mem_wmask_o;
  logic [XLEN-1:0]   mem_wdata_o;
  logic              mem_wdata_ready_i;

  logic              wb_valid_o;
  logic              wb_ready_i;
  logic [XLEN-1:0]   wb_rdata_o;
  logic [4:0]        wb_rd_o;
  logic              wb_misalign_o;

  // LSU side
  modport slave (
    input  ex_valid_i, ex_is_store_i, ex_size_i, ex_unsigned_i, ex_addr_i, ex_wdata_i, ex_rd_i,
    input  mem_rdata_i, mem_rdata_valid_i, mem_wdata_ready_i, wb_ready_i,
    output ex_ready_o, mem_read_addr_o, mem_valid_o, mem_rmask_o,
    output mem_write_addr_o, mem_write_valid_o, mem_wmask_o, mem_wdata_o,
    output wb_valid_o, wb_rdata_o, wb_rd_o, wb_misalign_o
  );

  // EX / arbiter / WB side
  modport master (
    output ex_valid_i, ex_is_store_i, ex_size_i, ex_unsigned_i, ex_addr_i, ex_wdata_i, ex_rd_i,
    output mem_rdata_i, mem_rdata_valid_i, mem_wdata_ready_i, wb_ready_i,
    input  ex_ready_o, mem_read_addr_o, mem_valid_o, mem_rmask_o,
    input  mem_write_addr_o, mem_write_valid_o, mem_wmask_o, mem_wdata_o,
    input  wb_valid_o, wb_rdata_o, wb_rd_o, wb_misalign_o
  );

endinterface

// File: rtl/mem_lsu_align.sv
// Combinational byte-lane alignment: masks, store shift, load shift/extend, misalign.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  input  logic [2:0]      off_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [7:0]      mask_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] load_o,
  output logic            misalign_o
);

  // Truncate a right-aligned value to the access size and sign/zero extend it.
  function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] v,
                                                  input logic [1:0] sz, input logic uns);
    logic signed [XLEN-1:0] r;
    case (sz)
      SZ_BYTE: r = uns ? {{(XLEN-8){1'b0}}, v[7:0]}   : {{(XLEN-8){v[7]}}, v[7:0]};
      SZ_HALF: r = uns ? {{(XLEN-16){1'b0}}, v[15:0]} : {{(XLEN-16){v[15]}}, v[15:0]};
      SZ_WORD: r = uns ? {{(XLEN-32){1'b0}}, v[31:0]} : {{(XLEN-32){v[31]}}, v[31:0]};
      default: r = v;
    endcase
    extend_load = r;
  endfunction

  logic [7:0]      bmask;
  logic [5:0]      shamt;
  logic [XLEN-1:0] wkeep;

  // Lane steering; store bytes outside the access size are zeroed before shifting.
  always_comb begin
    bmask = size_byte_mask(size_i);
    shamt = {off_i, 3'b000};
    wkeep = '0;
    for (int i = 0; i < 8; i++) begin
      wkeep[8*i +: 8] = wdata_i[8*i +: 8] & {8{bmask[i]}};
    end
    mask_o     = bmask << off_i;
    wdata_o    = wkeep << shamt;
    load_o     = extend_load(rdata_i >> shamt, size_i, unsigned_i);
    misalign_o = lsu_misaligned(size_i, off_i);
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: accepts one memory op from EX, runs it on the arbiter, hands result to WB.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  mem_lsu_if.slave lsu_io
);

  state_e            state_q, state_d;
  logic              armed_q;
  logic              is_store_q, uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q, rdata_q;
  logic [4:0]        rd_q;

  logic [7:0]        lane_mask;
  logic [XLEN-1:0]   lane_wdata, lane_load;
  logic              lane_misal;
  logic              accept;
  logic [ADDR_W-1:0] bus_addr;

  // armed_q holds ex_ready_o low for the arbiter's idle cycle after reset release.
  assign accept   = (state_q == S_IDLE) & armed_q & lsu_io.ex_valid_i;
  assign bus_addr = {addr_q[ADDR_W-1:3], 3'b000};

  mem_lsu_align u_lsu_align (
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .off_i      (addr_q[2:0]),
    .wdata_i    (wdata_q),
    .rdata_i    (lsu_io.mem_rdata_i),
    .mask_o     (lane_mask),
    .wdata_o    (lane_wdata),
    .load_o     (lane_load),
    .misalign_o (lane_misal)
  );

  // State register and post-reset arming flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  // Latch the op on acceptance and capture the aligned load result on return.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_store_q <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      rdata_q    <= '0;
    end else if (accept) begin
      is_store_q <= lsu_io.ex_is_store_i;
      uns_q      <= lsu_io.ex_unsigned_i;
      size_q     <= lsu_io.ex_size_i;
      addr_q     <= lsu_io.ex_addr_i;
      wdata_q    <= lsu_io.ex_wdata_i;
      rd_q       <= lsu_io.ex_rd_i;
      rdata_q    <= '0;
    end else if ((state_q == S_RD_WAIT) && lsu_io.mem_rdata_valid_i && !is_store_q) begin
      rdata_q <= lane_load;
    end
  end

  // Next-state and state-decoded outputs; everything idles at zero.
  always_comb begin
    state_d                  = state_q;
    lsu_io.ex_ready_o        = 1'b0;
    lsu_io.mem_valid_o       = 1'b0;
    lsu_io.mem_read_addr_o   = '0;
    lsu_io.mem_rmask_o       = '0;
    lsu_io.mem_write_valid_o = 1'b0;
    lsu_io.mem_write_addr_o  = '0;
    lsu_io.mem_wmask_o       = '0;
    lsu_io.mem_wdata_o       = '0;
    lsu_io.wb_valid_o        = 1'b0;
    lsu_io.wb_rdata_o        = '0;
    lsu_io.wb_rd_o           = '0;
    lsu_io.wb_misalign_o     = 1'b0;
    case (state_q)
      S_IDLE: begin
        lsu_io.ex_ready_o = armed_q;
        if (accept) begin
          if (lsu_misaligned(lsu_io.ex_size_i, lsu_io.ex_addr_i[2:0])) state_d = S_DONE;
          else if (lsu_io.ex_is_store_i)                                state_d = S_WR_REQ;
          else                                                          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        lsu_io.mem_valid_o     = 1'b1;
        lsu_io.mem_read_addr_o = bus_addr;
        lsu_io.mem_rmask_o     = lane_mask;
        if (lsu_io.mem_rdata_valid_i) state_d = S_DONE;
      end
      S_WR_REQ: begin
        lsu_io.mem_write_valid_o = 1'b1;
        lsu_io.mem_write_addr_o  = bus_addr;
        lsu_io.mem_wmask_o       = lane_mask;
        lsu_io.mem_wdata_o       = lane_wdata;
        state_d                  = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        lsu_io.mem_write_addr_o = bus_addr;
        lsu_io.mem_wmask_o      = lane_mask;
        lsu_io.mem_wdata_o      = lane_wdata;
        if (lsu_io.mem_wdata_ready_i) state_d = S_DONE;
      end
      S_DONE: begin
        lsu_io.wb_valid_o    = 1'b1;
        lsu_io.wb_rdata_o    = rdata_q;
        lsu_io.wb_rd_o       = rd_q;
        lsu_io.wb_misalign_o = lane_misal;
        if (lsu_io.wb_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: loads, stores, misalign, WB backpressure, reset mid-op.
module tb_mem_lsu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errs    = 0;

  always #5 clk = ~clk;

  mem_lsu_if bus ();

  mem_lsu dut (
    .clk    (clk),
    .rst    (rst),
    .lsu_io (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge; read and write valids must never overlap.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("no_overlap", {63'b0, bus.mem_valid_o & bus.mem_write_valid_o}, 64'd0);
  endtask

  task automatic present(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [63:0] wd, input logic [4:0] rd);
    bus.ex_valid_i    = 1'b1;
    bus.ex_is_store_i = st;
    bus.ex_size_i     = sz;
    bus.ex_unsigned_i = uns;
    bus.ex_addr_i     = addr;
    bus.ex_wdata_i    = wd;
    bus.ex_rd_i       = rd;
  endtask

  // Full load with the arbiter returning data so wb_valid_o appears at T+5.
  task automatic run_load(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                          input logic uns, input logic [4:0] rd, input logic [63:0] mem,
                          input logic [7:0] emask, input logic [63:0] edata);
    present(1'b0, sz, uns, addr, 64'h0, rd);
    tick();
    bus.ex_valid_i = 1'b0;
    chk({tag, "_mvalid"}, {63'b0, bus.mem_valid_o}, 64'd1);
    chk({tag, "_raddr"}, {32'b0, bus.mem_read_addr_o}, {32'b0, addr[31:3], 3'b000});
    chk({tag, "_rmask"}, {56'b0, bus.mem_rmask_o}, {56'b0, emask});
    chk({tag, "_exrdy_busy"}, {63'b0, bus.ex_ready_o}, 64'd0);
    repeat (3) tick();
    chk({tag, "_wbv_early"}, {63'b0, bus.wb_valid_o}, 64'd0);
    bus.mem_rdata_i       = mem;
    bus.mem_rdata_valid_i = 1'b1;
    chk({tag, "_mvalid_ret"}, {63'b0, bus.mem_valid_o}, 64'd1);
    chk({tag, "_rmask_ret"}, {56'b0, bus.mem_rmask_o}, {56'b0, emask});
    tick();
    bus.mem_rdata_valid_i = 1'b0;
    bus.mem_rdata_i       = ~mem;
    chk({tag, "_wbv"}, {63'b0, bus.wb_valid_o}, 64'd1);
    chk({tag, "_rdata"}, bus.wb_rdata_o, edata);
    chk({tag, "_rd"}, {59'b0, bus.wb_rd_o}, {59'b0, rd});
    chk({tag, "_mis"}, {63'b0, bus.wb_misalign_o}, 64'd0);
    chk({tag, "_mvalid_off"}, {63'b0, bus.mem_valid_o}, 64'd0);
    tick();
    chk({tag, "_rdata_hold"}, bus.wb_rdata_o, edata);
    bus.wb_ready_i = 1'b1;
    tick();
    bus.wb_ready_i = 1'b0;
    chk({tag, "_wbv_clr"}, {63'b0, bus.wb_valid_o}, 64'd0);
    chk({tag, "_exrdy_back"}, {63'b0, bus.ex_ready_o}, 64'd1);
  endtask

  initial begin
    bus.ex_valid_i        = 1'b0;
    bus.ex_is_store_i     = 1'b0;
    bus.ex_size_i         = 2'd0;
    bus.ex_unsigned_i     = 1'b0;
    bus.ex_addr_i         = '0;
    bus.ex_wdata_i        = '0;
    bus.ex_rd_i           = '0;
    bus.mem_rdata_i       = '0;
    bus.mem_rdata_valid_i = 1'b0;
    bus.mem_wdata_ready_i = 1'b0;
    bus.wb_ready_i        = 1'b0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_exrdy", {63'b0, bus.ex_ready_o}, 64'd0);
    chk("rst_mvalid", {63'b0, bus.mem_valid_o}, 64'd0);
    chk("rst_wvalid", {63'b0, bus.mem_write_valid_o}, 64'd0);
    chk("rst_wbv", {63'b0, bus.wb_valid_o}, 64'd0);
    chk("rst_wbdata", bus.wb_rdata_o, 64'd0);
    chk("rst_raddr", {32'b0, bus.mem_read_addr_o}, 64'd0);
    rst = 1'b0;
    chk("post_rst_exrdy_low", {63'b0, bus.ex_ready_o}, 64'd0);
    tick();
    chk("post_rst_exrdy_high", {63'b0, bus.ex_ready_o}, 64'd1);

    // Signed byte load at offset 3
    run_load("lb", 32'h8000_0003, 2'd0, 1'b0, 5'd5, 64'h0000_0000_AB00_0000,
             8'h08, 64'hFFFF_FFFF_FFFF_FFAB);

    // Unsigned half load at offset 2
    run_load("lhu", 32'h8000_0002, 2'd1, 1'b1, 5'd11, 64'h0000_0000_F00D_0000,
             8'h0C, 64'h0000_0000_0000_F00D);

    // Signed half load at offset 6
    run_load("lh", 32'h8000_0006, 2'd1, 1'b0, 5'd12, 64'h8765_0000_0000_0000,
             8'hC0, 64'hFFFF_FFFF_FFFF_8765);

    // Half store at offset 6, upper source bytes must be zeroed
    present(1'b1, 2'd1, 1'b0, 32'h8000_0006, 64'hDEAD_BEEF_CAFE_1234, 5'd9);
    tick();
    bus.ex_valid_i = 1'b0;
    chk("sh_wvalid", {63'b0, bus.mem_write_valid_o}, 64'd1);
    chk("sh_wmask", {56'b0, bus.mem_wmask_o}, 64'hC0);
    chk("sh_wdata", bus.mem_wdata_o, 64'h1234_0000_0000_0000);
    chk("sh_waddr", {32'b0, bus.mem_write_addr_o}, 64'h8000_0000);
    chk("sh_mvalid", {63'b0, bus.mem_valid_o}, 64'd0);
    tick();
    chk("sh_wvalid_once", {63'b0, bus.mem_write_valid_o}, 64'd0);
    chk("sh_wmask_hold", {56'b0, bus.mem_wmask_o}, 64'hC0);
    chk("sh_wdata_hold", bus.mem_wdata_o, 64'h1234_0000_0000_0000);
    tick();
    tick();
    chk("sh_wbv_early", {63'b0, bus.wb_valid_o}, 64'd0);
    bus.mem_wdata_ready_i = 1'b1;
    tick();
    bus.mem_wdata_ready_i = 1'b0;
    chk("sh_wbv", {63'b0, bus.wb_valid_o}, 64'd1);
    chk("sh_wbdata", bus.wb_rdata_o, 64'd0);
    chk("sh_mis", {63'b0, bus.wb_misalign_o}, 64'd0);

    // WB backpressure: DONE held 10 cycles with a new op waiting
    present(1'b0, 2'd3, 1'b0, 32'h8000_0000, 64'h0, 5'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_wbv", {63'b0, bus.wb_valid_o}, 64'd1);
      chk("bp_wbdata", bus.wb_rdata_o, 64'd0);
      chk("bp_rd", {59'b0, bus.wb_rd_o}, 64'd9);
      chk("bp_exrdy", {63'b0, bus.ex_ready_o}, 64'd0);
      chk("bp_mvalid", {63'b0, bus.mem_valid_o}, 64'd0);
      chk("bp_wvalid", {63'b0, bus.mem_write_valid_o}, 64'd0);
    end
    bus.ex_valid_i = 1'b0;
    bus.wb_ready_i = 1'b1;
    tick();
    bus.wb_ready_i = 1'b0;
    chk("bp_release", {63'b0, bus.wb_valid_o}, 64'd0);

    // Misaligned word load: straight to DONE, no bus access
    present(1'b0, 2'd2, 1'b0, 32'h8000_0002, 64'h0, 5'd7);
    tick();
    bus.ex_valid_i = 1'b0;
    chk("mis_wbv", {63'b0, bus.wb_valid_o}, 64'd1);
    chk("mis_flag", {63'b0, bus.wb_misalign_o}, 64'd1);
    chk("mis_rdata", bus.wb_rdata_o, 64'd0);
    chk("mis_mvalid", {63'b0, bus.mem_valid_o}, 64'd0);
    chk("mis_rd", {59'b0, bus.wb_rd_o}, 64'd7);
    bus.wb_ready_i = 1'b1;
    tick();
    bus.wb_ready_i = 1'b0;
    chk("mis_release", {63'b0, bus.wb_valid_o}, 64'd0);

    // Reset while waiting for read data
    present(1'b0, 2'd2, 1'b1, 32'h8000_0000, 64'h0, 5'd3);
    tick();
    bus.ex_valid_i = 1'b0;
    chk("rrst_mvalid_pre", {63'b0, bus.mem_valid_o}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rrst_mvalid", {63'b0, bus.mem_valid_o}, 64'd0);
    chk("rrst_raddr", {32'b0, bus.mem_read_addr_o}, 64'd0);
    chk("rrst_rmask", {56'b0, bus.mem_rmask_o}, 64'd0);
    chk("rrst_wbv", {63'b0, bus.wb_valid_o}, 64'd0);
    chk("rrst_exrdy", {63'b0, bus.ex_ready_o}, 64'd0);
    bus.mem_rdata_valid_i = 1'b1;
    tick();
    bus.mem_rdata_valid_i = 1'b0;
    chk("rrst_exrdy_arm", {63'b0, bus.ex_ready_o}, 64'd1);
    chk("rrst_no_wbv", {63'b0, bus.wb_valid_o}, 64'd0);

    // Back-to-back: unsigned word load then double store
    run_load("lwu", 32'h8000_0004, 2'd2, 1'b1, 5'd4, 64'h8000_0000_0000_0000,
             8'hF0, 64'h0000_0000_8000_0000);
    present(1'b1, 2'd3, 1'b0, 32'h8000_0008, 64'h0102_0304_0506_0708, 5'd2);
    tick();
    bus.ex_valid_i = 1'b0;
    chk("sd_wvalid", {63'b0, bus.mem_write_valid_o}, 64'd1);
    chk("sd_wmask", {56'b0, bus.mem_wmask_o}, 64'hFF);
    chk("sd_wdata", bus.mem_wdata_o, 64'h0102_0304_0506_0708);
    chk("sd_waddr", {32'b0, bus.mem_write_addr_o}, 64'h8000_0008);
    tick();
    tick();
    tick();
    bus.mem_wdata_ready_i = 1'b1;
    tick();
    bus.mem_wdata_ready_i = 1'b0;
    chk("sd_wbv", {63'b0, bus.wb_valid_o}, 64'd1);
    chk("sd_wbdata", bus.wb_rdata_o, 64'd0);
    chk("sd_rd", {59'b0, bus.wb_rd_o}, 64'd2);
    bus.wb_ready_i = 1'b1;
    tick();
    bus.wb_ready_i = 1'b0;
    chk("sd_release", {63'b0, bus.wb_valid_o}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
